// File: rtl/ovc_credit_status.sv
// ovc_credit_status: per-output-port OVC ownership and downstream credit tracker.
// Revision 1.0 - initial release.
`default_nettype none

module ovc_credit_status #(
  parameter  int V        = 4,
  parameter  int B        = 4,
  parameter  int DEBUG_EN = 1,
  localparam int CW       = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V-1:0]    ovc_allocated_in,
  input  logic            flit_wr,
  input  logic [V-1:0]    flit_vc,
  input  logic            flit_tail,
  input  logic [V-1:0]    credit_in,
  output logic [V-1:0]    ovc_status,
  output logic [V-1:0]    ovc_avail,
  output logic [V-1:0]    ovc_not_full,
  output logic [V*CW-1:0] credit_cnt_all,
  output logic            err
);

  localparam logic [0:0]    FREE   = 1'b0;
  localparam logic [0:0]    BUSY   = 1'b1;
  localparam logic [CW-1:0] FULL_C = CW'(B);

  logic [CW-1:0] cnt [V];
  logic [V-1:0]  state, state_nxt;
  logic [V-1:0]  dec, inc, tail_dec;
  logic [V-1:0]  at_zero, at_full, avail;
  logic [V-1:0]  underflow, overflow, bad_grant, free_flit;
  logic          not_onehot, err_now;

  always_comb begin
    dec      = flit_wr ? flit_vc : '0;
    inc      = credit_in;
    tail_dec = flit_tail ? dec : '0;
    for (int i = 0; i < V; i++) begin
      at_zero[i] = (cnt[i] == '0);
      at_full[i] = (cnt[i] == FULL_C);
    end
    // A VC is only handed out again once every downstream buffer slot is free.
    avail = ~state & at_full;
  end

  always_comb begin
    underflow  = dec & ~inc & at_zero;
    overflow   = inc & ~dec & at_full;
    bad_grant  = ovc_allocated_in & ~avail;
    free_flit  = dec & ~state;
    not_onehot = flit_wr && ((flit_vc == '0) || ((flit_vc & (flit_vc - 1'b1)) != '0));
    err_now    = (|underflow) | (|overflow) | (|bad_grant) | (|free_flit) | not_onehot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < V; i++) cnt[i] <= FULL_C;
    end else begin
      for (int i = 0; i < V; i++) begin
        if (dec[i] && !inc[i] && !at_zero[i])
          cnt[i] <= cnt[i] - 1'b1;
        else if (inc[i] && !dec[i] && !at_full[i])
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (err_now)
      err <= 1'b1;
  end

  // Ownership FSM, one bit per VC: register, next-state, outputs.
  always_ff @(posedge clk) begin
    if (reset)
      state <= {V{FREE}};
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    for (int i = 0; i < V; i++) begin
      case (state[i])
        FREE:    if (ovc_allocated_in[i] && avail[i]) state_nxt[i] = BUSY;
        BUSY:    if (tail_dec[i]) state_nxt[i] = FREE;
        default: state_nxt[i] = FREE;
      endcase
    end
  end

  always_comb begin
    ovc_status   = state;
    ovc_avail    = avail;
    ovc_not_full = ~at_zero;
    for (int i = 0; i < V; i++) credit_cnt_all[i*CW +: CW] = cnt[i];
  end

  if (DEBUG_EN != 0) begin : g_debug
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < V; i++) assert (cnt[i] <= FULL_C);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ovc_credit_status.sv
// Directed self-checking bench for ovc_credit_status (V=4, B=4).
`default_nettype none

module tb_ovc_credit_status;

  localparam int V  = 4;
  localparam int B  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [V-1:0]  ovc_allocated_in;
  logic          flit_wr;
  logic [V-1:0]  flit_vc;
  logic          flit_tail;
  logic [V-1:0]  credit_in;
  logic [V-1:0]  ovc_status, ovc_avail, ovc_not_full;
  logic [V*CW-1:0] credit_cnt_all;
  logic          err;

  int total = 0;
  int bad   = 0;

  ovc_credit_status #(.V(V), .B(B), .DEBUG_EN(1)) dut (
    .clk(clk), .reset(reset), .ovc_allocated_in(ovc_allocated_in),
    .flit_wr(flit_wr), .flit_vc(flit_vc), .flit_tail(flit_tail),
    .credit_in(credit_in), .ovc_status(ovc_status), .ovc_avail(ovc_avail),
    .ovc_not_full(ovc_not_full), .credit_cnt_all(credit_cnt_all), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt_of(input int i);
    return credit_cnt_all[i*CW +: CW];
  endfunction

  task automatic clear_inputs();
    ovc_allocated_in = '0;
    flit_wr = 1'b0;
    flit_vc = '0;
    flit_tail = 1'b0;
    credit_in = '0;
  endtask

  // Drive is applied before the call; step past the edge, then clear inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic flit(input logic [V-1:0] vc, input logic tail);
    flit_wr = 1'b1; flit_vc = vc; flit_tail = tail;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    for (int i = 0; i < V; i++) begin
      total++;
      if (cnt_of(i) !== 3'd4) begin bad++; $display("FAIL reset_cnt%0d got=%0d exp=4", i, cnt_of(i)); end
    end
    total++; if (ovc_avail !== 4'b1111) begin bad++; $display("FAIL reset_avail got=%b exp=1111", ovc_avail); end
    total++; if (ovc_not_full !== 4'b1111) begin bad++; $display("FAIL reset_nf got=%b exp=1111", ovc_not_full); end
    total++; if (ovc_status !== 4'b0000) begin bad++; $display("FAIL reset_status got=%b exp=0000", ovc_status); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_grant_flits();
    ovc_allocated_in = 4'b0010;
    tick();
    total++; if (ovc_status !== 4'b0010) begin bad++; $display("FAIL grant_status got=%b exp=0010", ovc_status); end
    total++; if (ovc_avail !== 4'b1101) begin bad++; $display("FAIL grant_avail got=%b exp=1101", ovc_avail); end
    for (int k = 0; k < 4; k++) flit(4'b0010, 1'b0);
    total++; if (cnt_of(1) !== 3'd0) begin bad++; $display("FAIL drain_cnt1 got=%0d exp=0", cnt_of(1)); end
    total++; if (ovc_not_full !== 4'b1101) begin bad++; $display("FAIL drain_nf got=%b exp=1101", ovc_not_full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL drain_err got=%b exp=0", err); end
  endtask

  task automatic test_simul_inc_dec();
    ovc_allocated_in = 4'b0100;
    tick();
    flit_wr = 1'b1; flit_vc = 4'b0100; credit_in = 4'b0100;
    tick();
    total++; if (cnt_of(2) !== 3'd4) begin bad++; $display("FAIL simul_cnt2 got=%0d exp=4", cnt_of(2)); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL simul_err got=%b exp=0", err); end
  endtask

  task automatic test_tail_release();
    credit_in = 4'b0010;
    tick();
    total++; if (cnt_of(1) !== 3'd1) begin bad++; $display("FAIL pre_tail_cnt1 got=%0d exp=1", cnt_of(1)); end
    flit(4'b0010, 1'b1);
    total++; if (ovc_status !== 4'b0100) begin bad++; $display("FAIL tail_status got=%b exp=0100", ovc_status); end
    total++; if (ovc_avail[1] !== 1'b0) begin bad++; $display("FAIL tail_avail1 got=%b exp=0", ovc_avail[1]); end
    for (int k = 1; k <= 4; k++) begin
      credit_in = 4'b0010;
      tick();
      total++;
      if (ovc_avail[1] !== (k == 4)) begin bad++; $display("FAIL refill_avail1 k=%0d got=%b exp=%b", k, ovc_avail[1], (k == 4)); end
    end
    total++; if (cnt_of(1) !== 3'd4) begin bad++; $display("FAIL refill_cnt1 got=%0d exp=4", cnt_of(1)); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL refill_err got=%b exp=0", err); end
  endtask

  task automatic test_bad_grant();
    ovc_allocated_in = 4'b0001;
    tick();
    total++; if (ovc_status !== 4'b0101) begin bad++; $display("FAIL grant0_status got=%b exp=0101", ovc_status); end
    ovc_allocated_in = 4'b0001;
    tick();
    total++; if (ovc_status !== 4'b0101) begin bad++; $display("FAIL regrant_status got=%b exp=0101", ovc_status); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL regrant_err got=%b exp=1", err); end
    repeat (10) tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL sticky_err got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    ovc_allocated_in = 4'b0010;
    tick();
    flit(4'b0010, 1'b0);
    flit(4'b0010, 1'b0);
    total++; if (cnt_of(1) !== 3'd2) begin bad++; $display("FAIL mid_cnt1 got=%0d exp=2", cnt_of(1)); end
    reset = 1'b1;
    credit_in = 4'b0001;
    ovc_allocated_in = 4'b0100;
    tick();
    reset = 1'b0;
    total++; if (cnt_of(1) !== 3'd4) begin bad++; $display("FAIL rst_cnt1 got=%0d exp=4", cnt_of(1)); end
    total++; if (ovc_status !== 4'b0000) begin bad++; $display("FAIL rst_status got=%b exp=0000", ovc_status); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
  endtask

  task automatic test_underflow();
    ovc_allocated_in = 4'b1000;
    tick();
    for (int k = 0; k < 4; k++) flit(4'b1000, 1'b0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL pre_uf_err got=%b exp=0", err); end
    flit(4'b1000, 1'b0);
    total++; if (cnt_of(3) !== 3'd0) begin bad++; $display("FAIL uf_cnt3 got=%0d exp=0", cnt_of(3)); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL uf_err got=%b exp=1", err); end
  endtask

  task automatic test_overflow();
    do_reset();
    credit_in = 4'b1000;
    tick();
    total++; if (cnt_of(3) !== 3'd4) begin bad++; $display("FAIL of_cnt3 got=%0d exp=4", cnt_of(3)); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL of_err got=%b exp=1", err); end
  endtask

  task automatic test_multihot_flit();
    do_reset();
    ovc_allocated_in = 4'b0011;
    tick();
    total++; if (ovc_status !== 4'b0011) begin bad++; $display("FAIL mh_status got=%b exp=0011", ovc_status); end
    flit(4'b0011, 1'b0);
    total++; if (cnt_of(0) !== 3'd3) begin bad++; $display("FAIL mh_cnt0 got=%0d exp=3", cnt_of(0)); end
    total++; if (cnt_of(1) !== 3'd3) begin bad++; $display("FAIL mh_cnt1 got=%0d exp=3", cnt_of(1)); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL mh_err got=%b exp=1", err); end
  endtask

  task automatic test_free_flit();
    do_reset();
    flit(4'b0100, 1'b1);
    total++; if (cnt_of(2) !== 3'd3) begin bad++; $display("FAIL ff_cnt2 got=%0d exp=3", cnt_of(2)); end
    total++; if (ovc_status !== 4'b0000) begin bad++; $display("FAIL ff_status got=%b exp=0000", ovc_status); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ff_err got=%b exp=1", err); end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_grant_flits();
    test_simul_inc_dec();
    test_tail_release();
    test_bad_grant();
    test_reset_mid_packet();
    test_underflow();
    test_overflow();
    test_multihot_flit();
    test_free_flit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
